// File: rtl/mux_rr_sel.sv
// N-channel registered selector with valid/ready on every port.
// Picks a channel by direct index (mode 0) or a fair round-robin pointer (mode 1).
module mux_rr_sel #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [SELW-1:0] ptr;
  logic            load_ok;
  logic            grant;
  logic [SELW-1:0] gnt_ch;
  logic [W-1:0]    gnt_data;
  logic [N-1:0]    rot_valid;
  logic            rr_found;
  logic [SELW:0]   rr_off;
  logic [SELW:0]   rr_sum;
  logic            sel_hit;

  assign load_ok = !out_valid || out_ready;

  // Rotate valids so bit 0 is the channel at ptr; first set bit is the winner.
  always_comb begin
    rot_valid = N'({in_valid, in_valid} >> ptr);
    rr_found  = 1'b0;
    rr_off    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot_valid[j]) begin
        rr_found = 1'b1;
        rr_off   = (SELW+1)'(j);
      end
    end
    rr_sum = {1'b0, ptr} + rr_off;
    if (rr_sum >= (SELW+1)'(N)) rr_sum = rr_sum - (SELW+1)'(N);
  end

  // Out-of-range sel values match no channel, so they never grant.
  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i) && in_valid[i]) sel_hit = 1'b1;
    end
  end

  always_comb begin
    grant  = 1'b0;
    gnt_ch = '0;
    if (mode) begin
      grant  = rr_found;
      gnt_ch = rr_sum[SELW-1:0];
    end else begin
      grant  = sel_hit;
      gnt_ch = sel;
    end
    if (!load_ok || rst) grant = 1'b0;
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_ch == SELW'(i)) begin
        in_ready[i] = grant;
        gnt_data    = in_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt_ch;
      if (mode) ptr <= (gnt_ch == SELW'(N - 1)) ? '0 : gnt_ch + SELW'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_sel.sv
// Directed bench for mux_rr_sel: an N=8 instance for the main scenarios and an
// N=6 instance for out-of-range direct selects.
module tb_mux_rr_sel;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        rst6;
  logic [47:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_ready6;
  logic        mode6;
  logic [2:0]  sel6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  logic        out_valid6;
  logic        out_ready6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_rr_sel #(.N(8), .W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_rr_sel #(.N(6), .W(8)) dut6 (
    .clk(clk), .rst(rst6), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .mode(mode6), .sel(sel6), .out_data(out_data6),
    .out_ch(out_ch6), .out_valid(out_valid6), .out_ready(out_ready6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0) begin
        bad++;
        $display("FAIL reset_regs cyc%0d: got v=%b d=%h ch=%0d want v=0 d=00 ch=0", c, out_valid, out_data, out_ch);
      end
      total++;
      if (in_ready !== 8'h00) begin
        bad++;
        $display("FAIL reset_in_ready cyc%0d: got %h want 00", c, in_ready);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 8'h01) begin
      bad++;
      $display("FAIL reset_first_ready: got %h want 01", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_first_grant: got v=%b ch=%0d d=%h want v=1 ch=0 d=00", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_mode0_sweep();
    logic [7:0] exp_d;
    mode = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      total++;
      if (in_ready !== 8'(1 << s)) begin
        bad++;
        $display("FAIL sweep_ready sel=%0d: got %h want %h", s, in_ready, 8'(1 << s));
      end
      tick();
      exp_d = 8'(s * 8'h11);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_ch !== 3'(s)) begin
        bad++;
        $display("FAIL sweep_out sel=%0d: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d", s, out_valid, out_data, out_ch, exp_d, s);
      end
    end
  endtask

  task automatic test_rr_fairness();
    int exp_seq [8] = '{0, 2, 5, 7, 0, 2, 5, 7};
    logic [7:0] exp_d;
    mode = 1'b1; in_valid = 8'hA5; out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (in_ready !== 8'(1 << exp_seq[k])) begin
        bad++;
        $display("FAIL rr_ready beat%0d: got %h want %h", k, in_ready, 8'(1 << exp_seq[k]));
      end
      tick();
      exp_d = 8'(exp_seq[k] * 8'h11);
      total++;
      if (out_valid !== 1'b1 || out_ch !== 3'(exp_seq[k]) || out_data !== exp_d) begin
        bad++;
        $display("FAIL rr_out beat%0d: got ch=%0d d=%h v=%b want ch=%0d d=%h v=1", k, out_ch, out_data, out_valid, exp_seq[k], exp_d);
      end
    end
  endtask

  task automatic test_stall();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    do_reset();
    tick();
    out_ready = 1'b0;
    #1;
    total++;
    if (in_ready !== 8'h00) begin
      bad++;
      $display("FAIL stall_ready_comb: got %h want 00", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== 8'h00 || in_ready !== 8'h00) begin
        bad++;
        $display("FAIL stall_hold cyc%0d: got v=%b ch=%0d d=%h rdy=%h want v=1 ch=0 d=00 rdy=00", c, out_valid, out_ch, out_data, in_ready);
      end
      total++;
      if (dut.ptr !== 3'd1) begin
        bad++;
        $display("FAIL stall_ptr cyc%0d: got %0d want 1", c, dut.ptr);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 8'h02) begin
      bad++;
      $display("FAIL stall_release_ready: got %h want 02", in_ready);
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_ch !== 3'(k) || out_data !== 8'(k * 8'h11)) begin
        bad++;
        $display("FAIL stall_resume beat%0d: got ch=%0d d=%h want ch=%0d d=%h", k, out_ch, out_data, k, 8'(k * 8'h11));
      end
    end
  endtask

  task automatic test_invalid_sel();
    mode6 = 1'b0; sel6 = 3'd2; in_valid6 = 6'h3F; out_ready6 = 1'b1;
    rst6 = 1'b1;
    tick();
    rst6 = 1'b0;
    #1;
    total++;
    if (in_ready6 !== 6'b000100) begin
      bad++;
      $display("FAIL inv_valid_sel_ready: got %b want 000100", in_ready6);
    end
    tick();
    total++;
    if (out_valid6 !== 1'b1 || out_ch6 !== 3'd2 || out_data6 !== 8'h12) begin
      bad++;
      $display("FAIL inv_first_load: got v=%b ch=%0d d=%h want v=1 ch=2 d=12", out_valid6, out_ch6, out_data6);
    end
    for (int s = 7; s >= 6; s--) begin
      sel6 = 3'(s);
      #1;
      total++;
      if (in_ready6 !== 6'b000000) begin
        bad++;
        $display("FAIL inv_sel%0d_ready: got %b want 000000", s, in_ready6);
      end
      tick();
      total++;
      if (out_valid6 !== 1'b0 || out_ch6 !== 3'd2 || out_data6 !== 8'h12) begin
        bad++;
        $display("FAIL inv_sel%0d_out: got v=%b ch=%0d d=%h want v=0 ch=2 d=12", s, out_valid6, out_ch6, out_data6);
      end
    end
  endtask

  task automatic test_mid_reset();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (out_valid !== 1'b1 || out_ch !== 3'd3 || out_data !== 8'h33) begin
      bad++;
      $display("FAIL midrst_setup: got v=%b ch=%0d d=%h want v=1 ch=3 d=33", out_valid, out_ch, out_data);
    end
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 8'h00) begin
      bad++;
      $display("FAIL midrst_ready: got %h want 00", in_ready);
    end
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_ch !== 3'd0 || out_data !== 8'h00 || dut.ptr !== 3'd0) begin
      bad++;
      $display("FAIL midrst_clear: got v=%b ch=%0d d=%h ptr=%0d want v=0 ch=0 d=00 ptr=0", out_valid, out_ch, out_data, dut.ptr);
    end
    #1;
    total++;
    if (in_ready !== 8'h01) begin
      bad++;
      $display("FAIL midrst_next_ready: got %h want 01", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_ch !== 3'd0) begin
      bad++;
      $display("FAIL midrst_next_grant: got v=%b ch=%0d want v=1 ch=0", out_valid, out_ch);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = 64'h7766_5544_3322_1100; in_valid = '0; mode = 1'b0;
    sel = '0; out_ready = 1'b0;
    rst6 = 1'b1; in_data6 = 48'h15_14_13_12_11_10; in_valid6 = '0; mode6 = 1'b0;
    sel6 = '0; out_ready6 = 1'b0;
    #1;
    test_reset();
    test_mode0_sweep();
    test_rr_fairness();
    test_stall();
    test_invalid_sel();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
